// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter
//   Shares one UART transmitter between N_REQ byte-stream requesters.
//   Round-robin arbitration at packet granularity: once a requester is
//   granted, the grant stays with it until a byte flagged last has been
//   sent, or until MAX_PKT bytes have gone out (MAX_PKT = 0: no cap).
//   Each byte produces one tx_start pulse. The block then waits for
//   tx_done and, between bytes of one packet, idles for GAP cycles.
//
// Ports
//   clk, rst     system clock, asynchronous active-high reset
//   req_valid    per-requester byte valid
//   req_data     per-requester byte, requester i at [i*D_W +: D_W]
//   req_last     per-requester end-of-packet flag
//   req_ready    per-requester accept (valid & ready handshake)
//   tx_start     one-cycle start pulse to the transmitter
//   tx_data      byte to transmit, held until the next load
//   tx_done      transmitter completion pulse (only looked at in WAIT)
//   grant_id     current or most recent granted requester
//   busy         high whenever the FSM is not idle
//
// state  | meaning
// -------+------------------------------------------------------------
// IDLE   | no grant; arbitrate among valid requesters from rr_ptr
// SEND   | grant locked; take next byte from the granted requester
// WAIT   | byte handed to transmitter; wait for tx_done
// GAP    | inter-byte idle time before the next byte of the packet
module uart_tx_arbiter #(
    parameter int D_W     = 8,
    parameter int N_REQ   = 4,
    parameter int GAP     = 0,
    parameter int MAX_PKT = 0
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [N_REQ-1:0]         req_valid,
    input  logic [N_REQ*D_W-1:0]     req_data,
    input  logic [N_REQ-1:0]         req_last,
    output logic [N_REQ-1:0]         req_ready,
    output logic                     tx_start,
    output logic [D_W-1:0]           tx_data,
    input  logic                     tx_done,
    output logic [$clog2(N_REQ)-1:0] grant_id,
    output logic                     busy
);
    localparam int ID_W  = $clog2(N_REQ);
    localparam int CNT_W = $clog2(MAX_PKT + 2);
    localparam int GAP_W = $clog2(GAP + 2);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SEND = 2'd1,
        S_WAIT = 2'd2,
        S_GAP  = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [ID_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [ID_W-1:0]   grant_q, grant_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              last_q, last_d;
    logic [GAP_W-1:0]  gap_q, gap_d;
    logic              tx_start_q, tx_start_d;
    logic [D_W-1:0]    tx_data_q, tx_data_d;
    logic              busy_q, busy_d;

    logic [D_W-1:0]    req_bytes [N_REQ];
    logic              arb_found;
    logic [ID_W-1:0]   arb_idx;
    int                arb_sum;
    logic              cap_hit;

    always_comb begin
        for (int i = 0; i < N_REQ; i++) begin
            req_bytes[i] = req_data[i*D_W +: D_W];
        end
    end

    // Scan offsets from the far end down so the smallest offset from
    // rr_ptr is the last one written and therefore wins.
    always_comb begin
        arb_found = 1'b0;
        arb_idx   = '0;
        arb_sum   = 0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            arb_sum = int'(rr_ptr_q) + i;
            if (arb_sum >= N_REQ) begin
                arb_sum = arb_sum - N_REQ;
            end
            if (req_valid[ID_W'(arb_sum)]) begin
                arb_found = 1'b1;
                arb_idx   = ID_W'(arb_sum);
            end
        end
    end

    // The byte being accepted now is the MAX_PKT-th of this grant.
    assign cap_hit = (MAX_PKT != 0) && (cnt_q == CNT_W'(MAX_PKT - 1));

    always_comb begin
        req_ready = '0;
        if (state_q == S_SEND) begin
            req_ready[grant_q] = req_valid[grant_q];
        end
    end

    always_comb begin
        state_d    = state_q;
        rr_ptr_d   = rr_ptr_q;
        grant_d    = grant_q;
        cnt_d      = cnt_q;
        last_d     = last_q;
        gap_d      = gap_q;
        tx_start_d = 1'b0;
        tx_data_d  = tx_data_q;
        unique case (state_q)
            S_IDLE: begin
                if (arb_found) begin
                    grant_d = arb_idx;
                    cnt_d   = '0;
                    state_d = S_SEND;
                end
            end
            S_SEND: begin
                if (req_valid[grant_q]) begin
                    tx_data_d  = req_bytes[grant_q];
                    tx_start_d = 1'b1;
                    last_d     = req_last[grant_q] || cap_hit;
                    cnt_d      = cnt_q + 1'b1;
                    state_d    = S_WAIT;
                end
            end
            S_WAIT: begin
                if (tx_done) begin
                    if (last_q) begin
                        state_d  = S_IDLE;
                        rr_ptr_d = (grant_q == ID_W'(N_REQ - 1)) ? '0 : grant_q + 1'b1;
                    end else if (GAP == 0) begin
                        state_d = S_SEND;
                    end else begin
                        gap_d   = GAP_W'(GAP - 1);
                        state_d = S_GAP;
                    end
                end
            end
            S_GAP: begin
                if (gap_q == '0) begin
                    state_d = S_SEND;
                end else begin
                    gap_d = gap_q - 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            rr_ptr_q   <= '0;
            grant_q    <= '0;
            cnt_q      <= '0;
            last_q     <= 1'b0;
            gap_q      <= '0;
            tx_start_q <= 1'b0;
            tx_data_q  <= '0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            rr_ptr_q   <= rr_ptr_d;
            grant_q    <= grant_d;
            cnt_q      <= cnt_d;
            last_q     <= last_d;
            gap_q      <= gap_d;
            tx_start_q <= tx_start_d;
            tx_data_q  <= tx_data_d;
            busy_q     <= busy_d;
        end
    end

    assign tx_start = tx_start_q;
    assign tx_data  = tx_data_q;
    assign grant_id = grant_q;
    assign busy     = busy_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter with N_REQ=4, GAP=2, MAX_PKT=3.
// Packets are loaded in phases while the DUT is idle; a packet-level model
// turns each phase into the expected byte order (requester, data, release)
// and a monitor pops that queue on every tx_start.
module tb_uart_tx_arbiter;
    localparam int N_REQ   = 4;
    localparam int D_W     = 8;
    localparam int GAP     = 2;
    localparam int MAX_PKT = 3;
    localparam int ID_W    = $clog2(N_REQ);

    typedef struct packed {
        logic [D_W-1:0] data;
        logic           last;
    } byte_t;

    typedef struct packed {
        logic [ID_W-1:0] id;
        logic [D_W-1:0]  data;
        logic            rel;
    } exp_t;

    logic                 clk = 1'b0;
    logic                 rst;
    logic [N_REQ-1:0]     req_valid;
    logic [N_REQ*D_W-1:0] req_data;
    logic [N_REQ-1:0]     req_last;
    logic [N_REQ-1:0]     req_ready;
    logic                 tx_start;
    logic [D_W-1:0]       tx_data;
    logic                 tx_done;
    logic [ID_W-1:0]      grant_id;
    logic                 busy;

    byte_t           src_q [N_REQ][$];
    byte_t           mdl_q [N_REQ][$];
    exp_t            exp_q [$];
    int              hold_cnt [N_REQ];
    int              gcnt [N_REQ];
    int              mdl_rr = 0;
    int              n_cmp = 0;
    int              n_bad = 0;
    logic            cur_rel = 1'b0;
    logic [ID_W-1:0] cur_gid = '0;

    uart_tx_arbiter #(
        .D_W    (D_W),
        .N_REQ  (N_REQ),
        .GAP    (GAP),
        .MAX_PKT(MAX_PKT)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .req_valid(req_valid),
        .req_data (req_data),
        .req_last (req_last),
        .req_ready(req_ready),
        .tx_start (tx_start),
        .tx_data  (tx_data),
        .tx_done  (tx_done),
        .grant_id (grant_id),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int got, input int want);
        n_cmp++;
        if (got != want) begin
            n_bad++;
            $display("FAIL %s: got %0d (0x%0h) want %0d (0x%0h) at %0t", name, got, got, want, want, $time);
        end
    endtask

    task automatic check_min(input string name, input int got, input int lo);
        n_cmp++;
        if (got < lo) begin
            n_bad++;
            $display("FAIL %s: got %0d want at least %0d at %0t", name, got, lo, $time);
        end
    endtask

    task automatic add_byte(input int r, input int d, input bit l);
        byte_t b;
        b.data = D_W'(d);
        b.last = l;
        src_q[r].push_back(b);
        mdl_q[r].push_back(b);
    endtask

    // Packet-level reference: round-robin over requesters holding data,
    // the granted one keeps the line until last or MAX_PKT bytes.
    task automatic build_expected();
        int    r;
        int    cnt;
        bit    found;
        byte_t b;
        exp_t  e;
        forever begin
            found = 0;
            r = 0;
            for (int k = 0; k < N_REQ; k++) begin
                if (!found && mdl_q[(mdl_rr + k) % N_REQ].size() > 0) begin
                    found = 1;
                    r = (mdl_rr + k) % N_REQ;
                end
            end
            if (!found) break;
            cnt = 0;
            do begin
                b = mdl_q[r].pop_front();
                cnt++;
                e.id   = ID_W'(r);
                e.data = b.data;
                e.rel  = b.last || (MAX_PKT != 0 && cnt == MAX_PKT);
                exp_q.push_back(e);
            end while (!e.rel);
            mdl_rr = (r + 1) % N_REQ;
        end
    endtask

    function automatic bit srcs_empty();
        bit em = 1;
        for (int r = 0; r < N_REQ; r++) begin
            if (src_q[r].size() != 0) em = 0;
        end
        return em;
    endfunction

    task automatic wait_phase(input string name);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            #3;
            n++;
        end while (!(exp_q.size() == 0 && busy == 1'b0 && srcs_empty()) && n < 3000);
        check({name, "_drained"}, exp_q.size(), 0);
        check({name, "_idle"}, int'(busy), 0);
    endtask

    task automatic random_phase();
        int np;
        int len;
        for (int r = 0; r < N_REQ; r++) begin
            np = $urandom_range(0, 2);
            for (int k = 0; k < np; k++) begin
                len = $urandom_range(1, 6);
                for (int j = 0; j < len; j++) begin
                    add_byte(r, $urandom_range(0, 255), j == len - 1);
                end
            end
        end
        build_expected();
    endtask

    // Requesters: present the head of their queue; after a non-final byte
    // the granted requester may drop valid for a while to exercise the lock.
    initial begin : drivers
        byte_t b;
        req_valid = '0;
        req_data  = '0;
        req_last  = '0;
        for (int r = 0; r < N_REQ; r++) begin
            hold_cnt[r] = 0;
            gcnt[r]     = 0;
        end
        forever begin
            @(negedge clk);
            for (int r = 0; r < N_REQ; r++) begin
                if (rst) begin
                    req_valid[r] = 1'b0;
                end else if (hold_cnt[r] > 0) begin
                    hold_cnt[r]--;
                    req_valid[r] = 1'b0;
                end else if (src_q[r].size() > 0) begin
                    b = src_q[r][0];
                    req_valid[r] = 1'b1;
                    req_data[r*D_W +: D_W] = b.data;
                    req_last[r] = b.last;
                end else begin
                    req_valid[r] = 1'b0;
                end
            end
            #1;
            for (int r = 0; r < N_REQ; r++) begin
                if (req_valid[r] && req_ready[r]) begin
                    b = src_q[r].pop_front();
                    gcnt[r]++;
                    if (b.last || gcnt[r] == MAX_PKT) begin
                        gcnt[r] = 0;
                    end else if ($urandom_range(0, 3) == 0) begin
                        hold_cnt[r] = $urandom_range(1, 20);
                    end
                end
            end
        end
    end

    // Scoreboard monitor.
    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (rst) continue;
            if (req_ready != '0) begin
                check("ready_without_valid", int'(req_ready & ~req_valid), 0);
                if (exp_q.size() > 0) begin
                    check("ready_onehot_grant", int'(req_ready), 1 << exp_q[0].id);
                end else begin
                    check("ready_nothing_pending", int'(req_ready), 0);
                end
            end
            if (tx_start) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_tx_start", int'(tx_start), 0);
                end else begin
                    e = exp_q.pop_front();
                    check("tx_data", int'(tx_data), int'(e.data));
                    check("grant_id", int'(grant_id), int'(e.id));
                    cur_rel = e.rel;
                    cur_gid = e.id;
                end
            end
        end
    end

    // Transmitter model: tx_done 1..6 cycles after each tx_start, stray
    // tx_done pulses whenever no byte is outstanding, and timing checks of
    // busy and of the spacing to the next tx_start.
    initial begin : tx_model
        int              d;
        int              n;
        int              want;
        logic            rel;
        logic            exact;
        logic            have_start;
        logic [ID_W-1:0] g;
        tx_done    = 1'b0;
        have_start = 1'b0;
        forever begin
            if (!have_start) begin
                @(negedge clk);
                tx_done = 1'b0;
                if (rst) continue;
                if (!tx_start) begin
                    if ($urandom_range(0, 15) == 0) tx_done = 1'b1;
                    continue;
                end
            end
            have_start = 1'b0;
            d = $urandom_range(1, 6);
            repeat (d - 1) @(negedge clk);
            tx_done = 1'b1;
            @(negedge clk);
            tx_done = 1'b0;
            if (rst) continue;
            rel = cur_rel;
            g   = cur_gid;
            check("busy_after_done", int'(busy), rel ? 0 : 1);
            if (rel && exp_q.size() == 0) continue;
            want  = rel ? 3 : GAP + 2;
            exact = rel || (hold_cnt[g] == 0);
            n = 1;
            while (!tx_start && n < 80) begin
                @(negedge clk);
                n++;
            end
            if (!tx_start) begin
                check("next_start_timeout", n, want);
            end else begin
                if (exact) begin
                    check(rel ? "regrant_spacing" : "gap_spacing", n, want);
                end else begin
                    check_min("gap_spacing_min", n, want);
                end
                have_start = 1'b1;
            end
        end
    end

    initial begin : watchdog
        #600000;
        $display("FAIL watchdog: simulation did not finish, got timeout want completion");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
        $fatal(1, "watchdog");
    end

    initial begin : main
        int n;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_tx_start", int'(tx_start), 0);
        check("rst_tx_data", int'(tx_data), 0);
        check("rst_grant_id", int'(grant_id), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_req_ready", int'(req_ready), 0);
        rst = 1'b0;
        repeat (5) begin
            @(negedge clk);
            #3;
            check("idle_tx_start", int'(tx_start), 0);
            check("idle_busy", int'(busy), 0);
            check("idle_grant_id", int'(grant_id), 0);
            check("idle_req_ready", int'(req_ready), 0);
        end

        // Single packet from requester 2, with start latency.
        @(posedge clk);
        #1;
        add_byte(2, 8'h41, 0);
        add_byte(2, 8'h42, 0);
        add_byte(2, 8'h43, 1);
        build_expected();
        n = 0;
        @(negedge clk);
        while (!tx_start && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("start_latency", n, 2);
        wait_phase("single");

        // Contention between 0, 1 and 3.
        @(posedge clk);
        #1;
        add_byte(0, 8'h10, 0);
        add_byte(0, 8'h11, 1);
        add_byte(1, 8'h20, 0);
        add_byte(1, 8'h21, 1);
        add_byte(3, 8'h30, 0);
        add_byte(3, 8'h31, 1);
        build_expected();
        wait_phase("contention");

        // Requesters 0 and 1 again: fairness after the previous round.
        @(posedge clk);
        #1;
        add_byte(0, 8'h12, 1);
        add_byte(1, 8'h22, 1);
        build_expected();
        wait_phase("rerequest");

        // Long packet from 0 is cut every MAX_PKT bytes while 1 waits.
        @(posedge clk);
        #1;
        for (int j = 0; j < 5; j++) add_byte(0, 8'hA0 + j, j == 4);
        add_byte(1, 8'hB0, 0);
        add_byte(1, 8'hB1, 1);
        build_expected();
        wait_phase("cap");

        for (int p = 0; p < 15; p++) begin
            @(posedge clk);
            #1;
            random_phase();
            wait_phase("random");
        end

        // Reset while a byte is in WAIT.
        @(posedge clk);
        #1;
        add_byte(1, 8'h5A, 0);
        add_byte(1, 8'h5B, 1);
        build_expected();
        n = 0;
        @(negedge clk);
        while (!tx_start && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("pre_rst_start_seen", int'(tx_start), 1);
        #3;
        rst = 1'b1;
        #1;
        check("midrst_tx_start", int'(tx_start), 0);
        check("midrst_tx_data", int'(tx_data), 0);
        check("midrst_grant_id", int'(grant_id), 0);
        check("midrst_busy", int'(busy), 0);
        check("midrst_req_ready", int'(req_ready), 0);
        repeat (3) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
